uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-bit UART transmitter among up to `NUM_REQ` byte sources.
- Accepts one byte per grant from the winning requester and drives the transmitter's `txdata`/`dataok` inputs.
- Holds `txdata` stable for the whole frame, because the transmitter samples data bits during transmission.
- Times the frame with a local counter, because the transmitter exposes no busy or done signal.

Sits in the `clk50m` domain between the byte-producing logic and the UART TX.

---
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte sources.
// Captures one byte per grant, holds txdata for a locally timed frame and strobes dataok.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no frame in progress; arbitrate when enable is high
// ST_SEND | frame in progress; txdata frozen, cnt times the frame
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned FRAME_CYCLES  = 4800,
  parameter int unsigned DATAOK_CYCLES = 32
) (
  input  logic                   clk50m,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic [7:0]             txdata,
  output logic                   dataok,
  output logic                   busy,
  output logic [2:0]             cur_owner
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic [15:0] FRAME_LAST = 16'(FRAME_CYCLES - 1);
  localparam logic [15:0] DATAOK_LEN = 16'(DATAOK_CYCLES);
  localparam logic [3:0]  NREQ4      = 4'(NUM_REQ);

  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [7:0]           txdata_q, txdata_d;
  logic                 dataok_q, dataok_d;
  logic                 busy_q, busy_d;
  logic [2:0]           owner_q, owner_d;

  logic [7:0]           req_ext;
  logic [63:0]          data_ext;
  logic                 win_found;
  logic [2:0]           win_idx;
  logic [3:0]           cand;
  logic [3:0]           ptr_nxt;
  logic                 grant;

  always_ff @(posedge clk50m or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      ack_q    <= '0;
      txdata_q <= '0;
      dataok_q <= 1'b0;
      busy_q   <= 1'b0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      ack_q    <= ack_d;
      txdata_q <= txdata_d;
      dataok_q <= dataok_d;
      busy_q   <= busy_d;
      owner_q  <= owner_d;
    end
  end

  // Requests and bytes are zero-padded to 8 lanes so the search indexes uniformly.
  always_comb begin
    req_ext                   = '0;
    req_ext[NUM_REQ-1:0]      = req;
    data_ext                  = '0;
    data_ext[8*NUM_REQ-1:0]   = req_data;
    win_found                 = 1'b0;
    win_idx                   = '0;
    cand                      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + 4'(i);
      if (cand >= NREQ4) begin
        cand = cand - NREQ4;
      end
      if (!win_found && req_ext[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  assign grant   = (state_q == ST_IDLE) && enable && win_found;
  assign ptr_nxt = {1'b0, win_idx} + 4'd1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (cnt_q == FRAME_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    ack_d    = '0;
    txdata_d = txdata_q;
    dataok_d = 1'b0;
    busy_d   = 1'b0;
    owner_d  = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          for (int k = 0; k < NUM_REQ; k++) begin
            ack_d[k] = (win_idx == 3'(k));
          end
          txdata_d = data_ext[{win_idx, 3'b000} +: 8];
          owner_d  = win_idx;
          ptr_d    = (ptr_nxt >= NREQ4) ? 3'd0 : ptr_nxt[2:0];
          cnt_d    = '0;
          dataok_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      ST_SEND: begin
        if (cnt_q == FRAME_LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d    = cnt_q + 16'd1;
          busy_d   = 1'b1;
          dataok_d = (cnt_q + 16'd1) < DATAOK_LEN;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign ack       = ack_q;
  assign txdata    = txdata_q;
  assign dataok    = dataok_q;
  assign busy      = busy_q;
  assign cur_owner = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a frame-level model predicts grants,
// a monitor pops predictions on ack and checks strobes every cycle.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int FC = 20;
  localparam int DC = 4;

  logic        clk50m   = 1'b0;
  logic        reset    = 1'b1;
  logic        enable   = 1'b0;
  logic [3:0]  req      = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic [7:0]  txdata;
  logic        dataok;
  logic        busy;
  logic [2:0]  cur_owner;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .FRAME_CYCLES (FC),
    .DATAOK_CYCLES(DC)
  ) dut (
    .clk50m   (clk50m),
    .reset    (reset),
    .enable   (enable),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .txdata   (txdata),
    .dataok   (dataok),
    .busy     (busy),
    .cur_owner(cur_owner)
  );

  always #10 clk50m = ~clk50m;

  int edge_cnt = 0;
  always @(posedge clk50m) edge_cnt++;

  typedef struct {
    int         k;
    logic [7:0] b;
    int         e;
  } grant_t;

  grant_t     exp_q[$];
  grant_t     obs_q[$];
  int         m_ptr  = 0;
  int         m_free = 0;
  int         m_lg   = -1000;
  logic [7:0] m_tx   = '0;
  int         m_own  = 0;
  int         n_cmp  = 0;
  int         n_bad  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_free = 0;
    m_lg   = -1000;
    m_tx   = '0;
    m_own  = 0;
  endtask

  // A grant happens at the next edge if the arbiter is free then; the winner is
  // the first requester at or after the pointer, and the frame occupies FC+1 edges.
  task automatic model_step();
    int     e;
    int     k;
    int     idx;
    grant_t g;
    e = edge_cnt;
    if (!reset && enable && req != 4'd0 && e >= m_free) begin
      k = -1;
      for (int i = 0; i < NR; i++) begin
        idx = (m_ptr + i) % NR;
        if (k < 0 && req[idx[1:0]]) k = idx;
      end
      g.k = k;
      g.b = 8'(req_data >> (8 * k));
      g.e = e;
      exp_q.push_back(g);
      m_ptr  = (k + 1) % NR;
      m_free = e + FC + 1;
      m_lg   = e;
      m_tx   = g.b;
      m_own  = k;
    end
  endtask

  task automatic step(input logic rs, input logic en, input logic [3:0] r, input logic [31:0] d);
    @(negedge clk50m);
    reset    = rs;
    enable   = en;
    req      = r;
    req_data = d;
    if (rs) model_reset();
    model_step();
  endtask

  task automatic do_reset();
    repeat (2) step(1'b1, 1'b0, 4'd0, 32'd0);
  endtask

  initial begin
    grant_t g;
    grant_t o;
    int     e;
    int     own;
    forever begin
      @(posedge clk50m);
      #1;
      e = edge_cnt - 1;
      if (exp_q.size() > 0 && exp_q[0].e <= e) begin
        g = exp_q.pop_front();
        chk("ack_grant", 32'(ack), 32'(1 << g.k));
        chk("grant_txdata", 32'(txdata), 32'(g.b));
        own = -1;
        for (int k = 0; k < NR; k++) if (ack[k]) own = k;
        o.k = own;
        o.b = txdata;
        o.e = e;
        obs_q.push_back(o);
      end else begin
        chk("ack_quiet", 32'(ack), 32'd0);
      end
      chk("txdata_hold", 32'(txdata), 32'(m_tx));
      chk("cur_owner", 32'(cur_owner), 32'(m_own));
      chk("busy", 32'(busy), 32'(e >= m_lg && e <= m_lg + FC - 1));
      chk("dataok", 32'(dataok), 32'(e >= m_lg && e <= m_lg + DC - 1));
    end
  end

  initial begin
    int ev;
    int seq2[5];
    int seq3[5];
    seq2 = '{0, 1, 2, 3, 0};
    seq3 = '{3, 0, 3, 0, 3};

    repeat (3) step(1'b1, 1'b0, 4'd0, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_dataok", 32'(dataok), 32'd0);
    chk("reset_txdata", 32'(txdata), 32'd0);
    step(1'b0, 1'b0, 4'd0, 32'd0);

    // single request from requester 2, then pointer must favour 3
    obs_q.delete();
    step(1'b0, 1'b1, 4'b0100, 32'h11A52233);
    repeat (22) step(1'b0, 1'b1, 4'd0, $urandom());
    step(1'b0, 1'b1, 4'b1111, 32'h44556677);
    repeat (22) step(1'b0, 1'b1, 4'd0, $urandom());
    chk("s1_count", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() >= 2) begin
      chk("s1_owner", 32'(obs_q[0].k), 32'd2);
      chk("s1_byte", 32'(obs_q[0].b), 32'hA5);
      chk("s1_ptr_next", 32'(obs_q[1].k), 32'd3);
      chk("s1_byte_next", 32'(obs_q[1].b), 32'h44);
    end

    // all four requesting continuously from reset
    do_reset();
    obs_q.delete();
    repeat (100) step(1'b0, 1'b1, 4'b1111, 32'h13121110);
    chk("s2_count", 32'(obs_q.size()), 32'd5);
    if (obs_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("s2_owner", 32'(obs_q[i].k), 32'(seq2[i]));
        chk("s2_byte", 32'(obs_q[i].b), 32'(8'h10 + seq2[i]));
        if (i > 0) chk("s2_spacing", 32'(obs_q[i].e - obs_q[i-1].e), 32'(FC + 1));
      end
    end

    // fairness between 0 and 3 after a grant to 3
    do_reset();
    obs_q.delete();
    step(1'b0, 1'b1, 4'b1000, 32'hA0B0C0D0);
    repeat (90) step(1'b0, 1'b1, 4'b1001, 32'hA0B0C0D0);
    chk("s3_count", 32'(obs_q.size()), 32'd5);
    if (obs_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("s3_owner", 32'(obs_q[i].k), 32'(seq3[i]));
    end

    // random req/data/enable every cycle; hold checked by the monitor
    obs_q.delete();
    repeat (400) step(1'b0, ($urandom_range(0, 7) != 0), 4'($urandom()), $urandom());
    repeat (25) step(1'b0, 1'b1, 4'd0, $urandom());
    chk("s4_enough_grants", 32'(obs_q.size() >= 10), 32'd1);

    // enable dropped at cnt=5, frame still completes, grant on re-enable
    do_reset();
    obs_q.delete();
    step(1'b0, 1'b1, 4'b0001, 32'h000000C3);
    repeat (5) step(1'b0, 1'b1, 4'b0001, 32'h000000C3);
    repeat (40) step(1'b0, 1'b0, 4'b0001, 32'h000000C3);
    chk("s5_no_ack_disabled", 32'(obs_q.size()), 32'd1);
    step(1'b0, 1'b1, 4'b0001, 32'h000000C4);
    ev = edge_cnt;
    repeat (3) step(1'b0, 1'b1, 4'd0, 32'd0);
    chk("s5_count", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() >= 2) begin
      chk("s5_reenable_edge", 32'(obs_q[1].e), 32'(ev));
      chk("s5_reenable_byte", 32'(obs_q[1].b), 32'hC4);
    end

    // asynchronous reset mid-frame
    do_reset();
    obs_q.delete();
    step(1'b0, 1'b1, 4'b0001, 32'h0000005A);
    repeat (2) step(1'b0, 1'b1, 4'd0, 32'd0);
    @(posedge clk50m);
    #3;
    chk("s6_pre_dataok", 32'(dataok), 32'd1);
    chk("s6_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("s6_async_dataok", 32'(dataok), 32'd0);
    chk("s6_async_busy", 32'(busy), 32'd0);
    chk("s6_async_ack", 32'(ack), 32'd0);
    chk("s6_async_txdata", 32'(txdata), 32'd0);
    chk("s6_async_owner", 32'(cur_owner), 32'd0);
    repeat (2) step(1'b1, 1'b0, 4'd0, 32'd0);
    step(1'b0, 1'b1, 4'b0010, 32'h00007E00);
    ev = edge_cnt;
    repeat (3) step(1'b0, 1'b1, 4'd0, 32'd0);
    chk("s6_count", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() >= 2) begin
      chk("s6_owner", 32'(obs_q[1].k), 32'd1);
      chk("s6_edge", 32'(obs_q[1].e), 32'(ev));
      chk("s6_byte", 32'(obs_q[1].b), 32'h7E);
    end

    repeat (25) step(1'b0, 1'b1, 4'd0, 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
